// File: rtl/spi_rx_pkg.sv
// Shared widths, write command and FSM state encoding for the SPI write receiver.
package spi_rx_pkg;
  localparam int          CMD_W      = 8;
  localparam int          ADDR_W     = 24;
  localparam int          DATA_W     = 32;
  localparam int          FRAME_BITS = CMD_W + ADDR_W + DATA_W;
  localparam logic [7:0]  WR_CMD     = 8'hFF;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
endpackage

// File: rtl/spi_rx_slave.sv
// Write-only SPI slave: shifts cmd/addr/data off MOSI (MSB first) and emits a
// one-cycle write strobe when a complete frame carries the write command.
module spi_rx_slave #(
  parameter logic [7:0] WR_CMD = spi_rx_pkg::WR_CMD,
  parameter int         ADDR_W = spi_rx_pkg::ADDR_W,
  parameter int         DATA_W = spi_rx_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_address_out,
  output logic [DATA_W-1:0] wr_data_out
);
  import spi_rx_pkg::*;

  localparam int FRAME = CMD_W + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CMD_W-1:0]    cmd_sr;
  logic [ADDR_W-1:0]   addr_sr;
  logic [DATA_W-1:0]   data_sr;
  logic [DATA_W-1:0]   data_nxt;

  // Data word including the bit being sampled this edge, so the final bit
  // can be committed to the outputs on the same edge it arrives.
  assign data_nxt = {data_sr[DATA_W-2:0], spi_mosi};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cmd_sr         <= '0;
      addr_sr        <= '0;
      data_sr        <= '0;
      wr_en_out      <= 1'b0;
      wr_address_out <= '0;
      wr_data_out    <= '0;
    end else begin
      wr_en_out <= 1'b0;
      if (spi_cs_n) begin
        // Deselect aborts any partial frame without a strobe.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cmd_sr <= {cmd_sr[CMD_W-2:0], spi_mosi};
            cnt    <= cnt + CNT_W'(1);
            state  <= CMD;
          end
          CMD: begin
            cmd_sr <= {cmd_sr[CMD_W-2:0], spi_mosi};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CMD_W - 1)) state <= ADDR;
          end
          ADDR: begin
            addr_sr <= {addr_sr[ADDR_W-2:0], spi_mosi};
            cnt     <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CMD_W + ADDR_W - 1)) state <= DATA;
          end
          DATA: begin
            data_sr <= data_nxt;
            if (cnt == CNT_W'(FRAME - 1)) begin
              cnt   <= '0;
              state <= DONE;
              if (cmd_sr == WR_CMD) begin
                wr_en_out      <= 1'b1;
                wr_address_out <= addr_sr;
                wr_data_out    <= data_nxt;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_rx_slave.sv
// Directed bench for spi_rx_slave: nominal, foreign command, aborts, overrun,
// back-to-back frames and mid-frame reset.
module tb_spi_rx_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        wr_en_out;
  logic [23:0] wr_address_out;
  logic [31:0] wr_data_out;

  int errors = 0;
  int checks = 0;
  int strobes;
  logic last_en;

  spi_rx_slave dut (
    .clk(clk), .rst(rst), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .wr_en_out(wr_en_out), .wr_address_out(wr_address_out), .wr_data_out(wr_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit time: drive at negedge, let the rising edge sample, settle 1ns.
  task automatic drive(input logic cs, input logic b);
    @(negedge clk);
    spi_cs_n = cs;
    spi_mosi = b;
    @(posedge clk);
    #1;
  endtask

  // Shift the first nbits of a frame (extra bits toggle) and count strobes.
  task automatic send(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                      input int nbits, output int n, output logic en_last);
    logic [63:0] f;
    f = {c, a, d};
    n = 0;
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, (i < 64) ? f[63-i] : i[0]);
      if (wr_en_out) n++;
      if (i == 63) en_last = wr_en_out;
    end
    if (nbits < 64) en_last = wr_en_out;
  endtask

  initial begin
    rst = 1'b1; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 64'(wr_en_out), 64'h0);
    chk("rst_addr", 64'(wr_address_out), 64'h0);
    chk("rst_data", 64'(wr_data_out), 64'h0);
    @(negedge clk); rst = 1'b0;

    // nominal write
    send(8'hFF, 24'h123456, 32'hF1F1F1F1, 64, strobes, last_en);
    chk("nom_strobes", 64'(strobes), 64'd1);
    chk("nom_en_last", 64'(last_en), 64'd1);
    chk("nom_addr", 64'(wr_address_out), 64'h123456);
    chk("nom_data", 64'(wr_data_out), 64'hF1F1F1F1);
    drive(1'b1, 1'b0);
    chk("nom_en_clr", 64'(wr_en_out), 64'h0);
    chk("nom_addr_hold", 64'(wr_address_out), 64'h123456);
    chk("nom_data_hold", 64'(wr_data_out), 64'hF1F1F1F1);

    // foreign command dropped
    send(8'h03, 24'hABCDEF, 32'h0, 64, strobes, last_en);
    drive(1'b1, 1'b0);
    chk("foreign_strobes", 64'(strobes), 64'd0);
    chk("foreign_addr", 64'(wr_address_out), 64'h123456);
    chk("foreign_data", 64'(wr_data_out), 64'hF1F1F1F1);

    // abort after 40 bits, then a good frame
    send(8'hFF, 24'h555555, 32'h77777777, 40, strobes, last_en);
    drive(1'b1, 1'b0);
    chk("abort40_strobes", 64'(strobes), 64'd0);
    chk("abort40_addr", 64'(wr_address_out), 64'h123456);
    send(8'hFF, 24'h000001, 32'hDEADBEEF, 64, strobes, last_en);
    drive(1'b1, 1'b0);
    chk("post_abort_strobes", 64'(strobes), 64'd1);
    chk("post_abort_addr", 64'(wr_address_out), 64'h000001);
    chk("post_abort_data", 64'(wr_data_out), 64'hDEADBEEF);

    // cs_n rising on the would-be final bit edge aborts
    send(8'hFF, 24'h999999, 32'h88888888, 63, strobes, last_en);
    drive(1'b1, 1'b0);
    chk("abort63_strobes", 64'(strobes + int'(wr_en_out)), 64'd0);
    chk("abort63_data", 64'(wr_data_out), 64'hDEADBEEF);

    // overrun: 10 extra toggling bits
    send(8'hFF, 24'hA5A5A5, 32'h0BADF00D, 74, strobes, last_en);
    chk("over_strobes", 64'(strobes), 64'd1);
    chk("over_en_last", 64'(last_en), 64'd1);
    chk("over_addr", 64'(wr_address_out), 64'hA5A5A5);
    chk("over_data", 64'(wr_data_out), 64'h0BADF00D);
    drive(1'b1, 1'b0);

    // back-to-back with a single high cycle
    send(8'hFF, 24'h111111, 32'h11111111, 64, strobes, last_en);
    chk("b2b1_strobes", 64'(strobes), 64'd1);
    chk("b2b1_addr", 64'(wr_address_out), 64'h111111);
    chk("b2b1_data", 64'(wr_data_out), 64'h11111111);
    drive(1'b1, 1'b0);
    send(8'hFF, 24'h222222, 32'h22222222, 64, strobes, last_en);
    chk("b2b2_strobes", 64'(strobes), 64'd1);
    chk("b2b2_en_last", 64'(last_en), 64'd1);
    chk("b2b2_addr", 64'(wr_address_out), 64'h222222);
    chk("b2b2_data", 64'(wr_data_out), 64'h22222222);
    drive(1'b1, 1'b0);

    // reset at bit 20 of a frame
    send(8'hFF, 24'h333333, 32'h33333333, 20, strobes, last_en);
    @(negedge clk);
    rst = 1'b1; spi_cs_n = 1'b0; spi_mosi = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_en", 64'(wr_en_out), 64'h0);
    chk("rst_mid_addr", 64'(wr_address_out), 64'h0);
    chk("rst_mid_data", 64'(wr_data_out), 64'h0);
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 1'b0);
    send(8'hFF, 24'h654321, 32'hCAFEF00D, 64, strobes, last_en);
    chk("post_rst_strobes", 64'(strobes), 64'd1);
    chk("post_rst_addr", 64'(wr_address_out), 64'h654321);
    chk("post_rst_data", 64'(wr_data_out), 64'hCAFEF00D);
    drive(1'b1, 1'b0);
    chk("post_rst_en_clr", 64'(wr_en_out), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
